// File: rtl/mem_port_adapter.sv
// mem_port_adapter: RV32I multicycle memory port to word-addressed pmem.
// Optional feature macro: MEM_ADAPTER_TIMEOUT_EN (pmem wait timeout).
module mem_port_adapter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_misaligned,
  output logic        mem_timeout,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [31:0] pmem_wdata,
  output logic [3:0]  pmem_byte_enable,
  input  logic [31:0] pmem_rdata,
  input  logic        pmem_resp
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        mem_resp_q, mem_resp_d;
  logic        mem_misaligned_q, mem_misaligned_d;
  logic        pmem_read_q, pmem_read_d;
  logic        pmem_write_q, pmem_write_d;
  logic [31:0] pmem_address_q, pmem_address_d;
  logic [31:0] pmem_wdata_q, pmem_wdata_d;
  logic [3:0]  pmem_byte_enable_q, pmem_byte_enable_d;

  logic        req_byte;
  logic        req_half;
  logic        req_word;
  logic        req_mis;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;

  // funct3[2] only selects sign handling, which lives in the MDR mux.
  logic unused_ok;
  assign unused_ok = ^{mem_funct3[2], TIMEOUT_CYCLES};

`ifdef MEM_ADAPTER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] WaitLimit = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            mem_timeout_q, mem_timeout_d;
`endif

  // Decode size, alignment and lane placement of the incoming request.
  always_comb begin
    req_byte  = (mem_funct3[1:0] == 2'b00);
    req_half  = (mem_funct3[1:0] == 2'b01);
    req_word  = !req_byte && !req_half;
    req_mis   = (req_half && mem_address[0])
             || (req_word && (mem_address[1:0] != 2'b00));
    req_be    = 4'b1111;
    req_wdata = mem_wdata;
    unique case (1'b1)
      req_byte: begin
        req_be    = 4'b0001 << mem_address[1:0];
        req_wdata = {4{mem_wdata[7:0]}};
      end
      req_half: begin
        req_be    = 4'b0011 << mem_address[1:0];
        req_wdata = {2{mem_wdata[15:0]}};
      end
      default: begin
        req_be    = 4'b1111;
        req_wdata = mem_wdata;
      end
    endcase
  end

  // Next-state and registered-output logic of the handshake FSM.
  always_comb begin
    state_d            = state_q;
    off_d              = off_q;
    mem_rdata_d        = mem_rdata_q;
    mem_resp_d         = 1'b0;
    mem_misaligned_d   = 1'b0;
    pmem_read_d        = pmem_read_q;
    pmem_write_d       = pmem_write_q;
    pmem_address_d     = pmem_address_q;
    pmem_wdata_d       = pmem_wdata_q;
    pmem_byte_enable_d = pmem_byte_enable_q;
`ifdef MEM_ADAPTER_TIMEOUT_EN
    wait_cnt_d         = wait_cnt_q;
    mem_timeout_d      = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (mem_write || mem_read) begin
          if (req_mis) begin
            // Rejected before pmem sees anything.
            state_d          = DONE;
            mem_resp_d       = 1'b1;
            mem_misaligned_d = 1'b1;
            mem_rdata_d      = '0;
          end else begin
            off_d          = mem_address[1:0];
            pmem_address_d = {mem_address[31:2], 2'b00};
`ifdef MEM_ADAPTER_TIMEOUT_EN
            wait_cnt_d     = '0;
`endif
            if (mem_write) begin
              state_d            = WR;
              pmem_write_d       = 1'b1;
              pmem_wdata_d       = req_wdata;
              pmem_byte_enable_d = req_be;
            end else begin
              state_d            = RD;
              pmem_read_d        = 1'b1;
              pmem_byte_enable_d = 4'b1111;
            end
          end
        end
      end
      RD, WR: begin
        if (pmem_resp) begin
          state_d      = DONE;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
          mem_resp_d   = 1'b1;
          if (state_q == RD) begin
            mem_rdata_d = pmem_rdata >> {off_q, 3'b000};
          end else begin
            mem_rdata_d = '0;
          end
        end
`ifdef MEM_ADAPTER_TIMEOUT_EN
        else if (wait_cnt_q == WaitLimit) begin
          state_d       = DONE;
          pmem_read_d   = 1'b0;
          pmem_write_d  = 1'b0;
          mem_resp_d    = 1'b1;
          mem_timeout_d = 1'b1;
          mem_rdata_d   = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= IDLE;
      off_q              <= '0;
      mem_rdata_q        <= '0;
      mem_resp_q         <= 1'b0;
      mem_misaligned_q   <= 1'b0;
      pmem_read_q        <= 1'b0;
      pmem_write_q       <= 1'b0;
      pmem_address_q     <= '0;
      pmem_wdata_q       <= '0;
      pmem_byte_enable_q <= '0;
`ifdef MEM_ADAPTER_TIMEOUT_EN
      wait_cnt_q         <= '0;
      mem_timeout_q      <= 1'b0;
`endif
    end else begin
      state_q            <= state_d;
      off_q              <= off_d;
      mem_rdata_q        <= mem_rdata_d;
      mem_resp_q         <= mem_resp_d;
      mem_misaligned_q   <= mem_misaligned_d;
      pmem_read_q        <= pmem_read_d;
      pmem_write_q       <= pmem_write_d;
      pmem_address_q     <= pmem_address_d;
      pmem_wdata_q       <= pmem_wdata_d;
      pmem_byte_enable_q <= pmem_byte_enable_d;
`ifdef MEM_ADAPTER_TIMEOUT_EN
      wait_cnt_q         <= wait_cnt_d;
      mem_timeout_q      <= mem_timeout_d;
`endif
    end
  end

  assign mem_rdata        = mem_rdata_q;
  assign mem_resp         = mem_resp_q;
  assign mem_misaligned   = mem_misaligned_q;
  assign pmem_read        = pmem_read_q;
  assign pmem_write       = pmem_write_q;
  assign pmem_address     = pmem_address_q;
  assign pmem_wdata       = pmem_wdata_q;
  assign pmem_byte_enable = pmem_byte_enable_q;
`ifdef MEM_ADAPTER_TIMEOUT_EN
  assign mem_timeout      = mem_timeout_q;
`else
  assign mem_timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_adapter.sv
// tb_mem_port_adapter: timeline model of the memory port adapter.
// Directed accesses; per-cycle compare plus literal pins.
module tb_mem_port_adapter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_resp, mem_misaligned, mem_timeout;
  logic        pmem_read, pmem_write;
  logic [31:0] pmem_address, pmem_wdata, pmem_rdata;
  logic [3:0]  pmem_byte_enable;
  logic        pmem_resp;

  always #5 clk = ~clk;

  mem_port_adapter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_funct3(mem_funct3), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .mem_misaligned(mem_misaligned),
    .mem_timeout(mem_timeout),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_byte_enable(pmem_byte_enable),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic        chk_en = 1'b0;
  logic        exp_pr, exp_pw, exp_resp, exp_mis, exp_to;
  logic [31:0] exp_rdata, exp_addr, exp_wd;
  logic [3:0]  exp_be;
  logic        chk_fld, chk_wd;
  logic [31:0] obs_addr, obs_wd;
  logic [3:0]  obs_be;
  int          resp_pulses = 0;
  int          pr_seen = 0;
  int          pw_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pmem_read", 32'(pmem_read), 32'(exp_pr));
      chk("pmem_write", 32'(pmem_write), 32'(exp_pw));
      chk("mem_resp", 32'(mem_resp), 32'(exp_resp));
      chk("mem_misaligned", 32'(mem_misaligned), 32'(exp_mis));
      chk("mem_timeout", 32'(mem_timeout), 32'(exp_to));
      chk("mem_rdata", mem_rdata, exp_rdata);
      if (chk_fld) begin
        chk("pmem_address", pmem_address, exp_addr);
        chk("pmem_be", 32'(pmem_byte_enable), 32'(exp_be));
      end
      if (chk_wd) chk("pmem_wdata", pmem_wdata, exp_wd);
      if (pmem_read || pmem_write) begin
        obs_addr = pmem_address;
        obs_wd   = pmem_wdata;
        obs_be   = pmem_byte_enable;
      end
      if (mem_resp) resp_pulses++;
      if (pmem_read) pr_seen++;
      if (pmem_write) pw_seen++;
    end
  end

  function automatic int f_nb(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] f_wd(input logic [2:0] f3,
                                       input logic [31:0] wd);
    logic [31:0] r;
    int nb;
    nb = f_nb(f3);
    r  = '0;
    for (int i = 0; i < 4; i++)
      r[i*8 +: 8] = wd[(i % nb)*8 +: 8];
    return r;
  endfunction

  function automatic logic [3:0] f_be(input logic [2:0] f3,
                                      input logic [1:0] off);
    int m;
    m = ((1 << f_nb(f3)) - 1) << off;
    return m[3:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    exp_pr   = 1'b0;
    exp_pw   = 1'b0;
    exp_resp = 1'b0;
    exp_mis  = 1'b0;
    exp_to   = 1'b0;
    chk_fld  = 1'b0;
    chk_wd   = 1'b0;
  endtask

  task automatic idle_cycle();
    step();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    pmem_resp = 1'b0;
    quiet();
  endtask

  // k = cycle of pmem_resp after the request; k < 0 means never.
  task automatic access(input bit wr, input bit both,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int k,
                        input logic [31:0] prd);
    logic [1:0] off;
    bit         mis;
    int         last;
    off  = a[1:0];
    mis  = (int'(a % 32'(f_nb(f3))) != 0);
    last = (k < 0) ? TO : k;
    step();
    mem_write   = wr;
    mem_read    = !wr || both;
    mem_funct3  = f3;
    mem_address = a;
    mem_wdata   = wd;
    pmem_resp   = 1'b0;
    quiet();
    if (mis) begin
      step();
      exp_resp  = 1'b1;
      exp_mis   = 1'b1;
      exp_rdata = '0;
    end else begin
      for (int c = 1; c <= last; c++) begin
        step();
        exp_pr     = !wr;
        exp_pw     = wr;
        chk_fld    = 1'b1;
        chk_wd     = wr;
        exp_addr   = a & ~32'h3;
        exp_be     = wr ? f_be(f3, off) : 4'hF;
        exp_wd     = f_wd(f3, wd);
        pmem_resp  = (c == k);
        pmem_rdata = (c == k) ? prd : $urandom;
      end
      step();
      pmem_resp = 1'b0;
      quiet();
      exp_resp = 1'b1;
      if (k < 0) begin
        exp_to    = 1'b1;
        exp_rdata = '0;
      end else begin
        exp_rdata = wr ? 32'h0 : (prd >> (8 * off));
      end
    end
  endtask

  int rp0;

  initial begin
    rst         = 1'b1;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_funct3  = 3'b000;
    mem_address = '0;
    mem_wdata   = '0;
    pmem_rdata  = '0;
    pmem_resp   = 1'b0;
    quiet();
    exp_rdata = '0;
    exp_addr  = '0;
    exp_wd    = '0;
    exp_be    = '0;
    step();
    chk_fld = 1'b1;
    chk_wd  = 1'b1;
    chk_en  = 1'b1;
    step();
    rst = 1'b0;
    idle_cycle();

    pr_seen = 0;
    access(0, 0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF);
    chk("lit_lw_rdata", mem_rdata, 32'hDEADBEEF);
    chk("lit_lw_strobes", 32'(pr_seen), 32'd3);

    access(0, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80112233);
    chk("lit_lb_rdata", mem_rdata, 32'h00000080);
    chk("lit_lb_be", 32'(obs_be), 32'hF);

    access(0, 0, 3'b100, 32'h102, 32'h0, 2, 32'h11AA2233);
    chk("lit_lbu_rdata", mem_rdata, 32'h000011AA);
    access(0, 0, 3'b001, 32'h102, 32'h0, 2, 32'hBEEF1234);
    chk("lit_lh_rdata", mem_rdata, 32'h0000BEEF);

    access(1, 0, 3'b001, 32'h202, 32'h0000ABCD, 2, 32'h0);
    chk("lit_sh_addr", obs_addr, 32'h200);
    chk("lit_sh_be", 32'(obs_be), 32'hC);
    chk("lit_sh_wdata", obs_wd, 32'hABCDABCD);
    chk("lit_sh_rdata", mem_rdata, 32'h0);

    access(1, 0, 3'b000, 32'h301, 32'h123456C3, 1, 32'h0);
    chk("lit_sb_be", 32'(obs_be), 32'h2);
    chk("lit_sb_wdata", obs_wd, 32'hC3C3C3C3);
    access(1, 0, 3'b010, 32'h400, 32'hCAFEF00D, 4, 32'h0);
    access(0, 0, 3'b110, 32'h500, 32'h0, 1, 32'h76543210);

    pr_seen = 0;
    pw_seen = 0;
    access(0, 0, 3'b010, 32'h101, 32'h0, 1, 32'h0);
    chk("lit_mis_flag", 32'(mem_misaligned), 32'd1);
    chk("lit_mis_rdata", mem_rdata, 32'h0);
    access(1, 0, 3'b001, 32'h203, 32'h1111, 1, 32'h0);
    access(0, 0, 3'b001, 32'h201, 32'h0, 1, 32'h0);
    access(1, 0, 3'b010, 32'h402, 32'h2222, 1, 32'h0);
    access(0, 0, 3'b011, 32'h502, 32'h0, 1, 32'h0);
    chk("lit_mis_no_pmem", 32'(pr_seen + pw_seen), 32'd0);

    pw_seen = 0;
    access(1, 1, 3'b000, 32'h600, 32'h000000A5, 2, 32'h0);
    chk("lit_both_write", 32'(pw_seen), 32'd2);

    access(0, 0, 3'b010, 32'h700, 32'h0, 1, 32'h13572468);
    idle_cycle();
    rp0 = resp_pulses;
    step();
    mem_read    = 1'b1;
    mem_funct3  = 3'b010;
    mem_address = 32'h300;
    quiet();
    step();
    exp_pr   = 1'b1;
    chk_fld  = 1'b1;
    exp_addr = 32'h300;
    exp_be   = 4'hF;
    step();
    rst = 1'b1;
    step();
    rst       = 1'b0;
    mem_read  = 1'b0;
    quiet();
    chk_fld   = 1'b1;
    chk_wd    = 1'b1;
    exp_addr  = '0;
    exp_be    = '0;
    exp_wd    = '0;
    exp_rdata = '0;
    idle_cycle();
    step();
    pmem_resp  = 1'b1;
    pmem_rdata = 32'hFFFFFFFF;
    idle_cycle();
    idle_cycle();
    chk("lit_rst_no_resp", 32'(resp_pulses - rp0), 32'd0);

`ifdef MEM_ADAPTER_TIMEOUT_EN
    rp0 = resp_pulses;
    pr_seen = 0;
    access(0, 0, 3'b010, 32'h800, 32'h0, -1, 32'h0);
    chk("lit_to_flag", 32'(mem_timeout), 32'd1);
    chk("lit_to_strobes", 32'(pr_seen), 32'(TO));
    access(0, 0, 3'b010, 32'h804, 32'h0, TO, 32'h0BADF00D);
    chk("lit_to_edge_ok", mem_rdata, 32'h0BADF00D);
    access(1, 0, 3'b010, 32'h808, 32'h55AA55AA, -1, 32'h0);
    access(0, 0, 3'b001, 32'h80A, 32'h0, 2, 32'h9ABC0000);
    chk("lit_to_resp_cnt", 32'(resp_pulses - rp0), 32'd4);
`endif

    idle_cycle();
    idle_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
